// File: rtl/store_narrow_unit.sv
// store_narrow_unit
//   Write-side narrowing for the MIPS MEM stage. A register value is turned
//   into a byte, halfword or word store. The write data is lane-replicated
//   little-endian with matching byte enables, and is sent to data memory
//   through a single-outstanding req/ack handshake. Alignment is checked
//   before memory sees the store, and a stalled acknowledge is aborted once
//   a timeout expires.
//
// Ports
//   clk, reset        : system clock (rising edge), synchronous active-high reset
//   st_valid/st_ready : store handshake from the MEM stage
//   st_size           : 00 byte, 01 half, 10 word, 11 invalid
//   st_addr, st_data  : byte address and rt source data
//   st_done           : one-cycle completion pulse (success or error)
//   st_err            : qualifies st_done, the store failed
//   st_err_code       : 01 misaligned, 10 invalid size, 11 timeout, 00 none
//   mem_req/mem_ack   : data memory write handshake
//   mem_addr          : word-aligned address
//   mem_wdata, mem_be : lane-placed write data and byte enables
//
// state | meaning
// IDLE  | ready for a store; error stores complete from here directly
// BUSY  | mem_req asserted, waiting for mem_ack or the timeout

module store_narrow_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        st_err,
  output logic [1:0]  st_err_code,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE  = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic         r_done, w_done_nxt;
  logic         r_err, w_err_nxt;
  logic [1:0]   r_code, w_code_nxt;
  logic [29:0]  r_addr, w_addr_nxt;
  logic [31:0]  r_wdata, w_wdata_nxt;
  logic [3:0]   r_be, w_be_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic [3:0]   w_lane_be;
  logic [31:0]  w_lane_data;
  logic [1:0]   w_chk_code;
  logic         w_tmo_last;

  // Lane placement and alignment check on the incoming store
  always_comb begin
    w_lane_be   = 4'b0000;
    w_lane_data = 32'h0;
    w_chk_code  = ERR_NONE;
    case (st_size)
      2'b00: begin
        w_lane_be   = 4'b0001 << st_addr[1:0];
        w_lane_data = {4{st_data[7:0]}};
      end
      2'b01: begin
        w_lane_be   = st_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{st_data[15:0]}};
        if (st_addr[0]) w_chk_code = ERR_ALIGN;
      end
      2'b10: begin
        w_lane_be   = 4'b1111;
        w_lane_data = st_data;
        if (st_addr[1:0] != 2'b00) w_chk_code = ERR_ALIGN;
      end
      default: w_chk_code = ERR_SIZE;
    endcase
  end

  // Final wait cycle: an ack here still wins over the timeout
  assign w_tmo_last = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = r_code;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_be_nxt    = r_be;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (st_valid) begin
          if (w_chk_code != ERR_NONE) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
            w_code_nxt = w_chk_code;
            w_be_nxt   = 4'b0000;
          end else begin
            w_state_nxt = S_BUSY;
            w_addr_nxt  = st_addr[31:2];
            w_wdata_nxt = w_lane_data;
            w_be_nxt    = w_lane_be;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_code_nxt  = ERR_NONE;
          w_be_nxt    = 4'b0000;
        end else if (w_tmo_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_code_nxt  = ERR_TMO;
          w_be_nxt    = 4'b0000;
        end else if (TIMEOUT > 0) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_code  <= w_code_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_be    <= w_be_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign st_ready    = (r_state == S_IDLE);
  assign mem_req     = (r_state == S_BUSY);
  assign st_done     = r_done;
  assign st_err      = r_err;
  assign st_err_code = r_code;
  assign mem_addr    = {r_addr, 2'b00};
  assign mem_wdata   = r_wdata;
  assign mem_be      = r_be;

endmodule

// File: tb/tb_store_narrow_unit.sv
module tb_store_narrow_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_done;
  logic        st_err;
  logic [1:0]  st_err_code;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  store_narrow_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data),
    .st_done(st_done), .st_err(st_err), .st_err_code(st_err_code),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  be_done;
    logic        err;
    logic [1:0]  code;
    logic [7:0]  lat;
    logic [7:0]  req_n;
    logic        unstable;
    logic        finished;
    logic        req_at_done;
  } obs_t;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_after;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
    logic [1:0]  code;
    int          lat;
    int          req_n;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: lanes derived from byte offsets and arithmetic replication
  function automatic void ref_model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                    output logic [3:0] be, output logic [31:0] wd, output logic [1:0] code);
    int nbytes;
    int off;
    off = int'(a % 4);
    be = 4'b0;
    wd = 32'h0;
    nbytes = 1 << sz;
    if (sz == 2'd3) code = 2'd2;
    else if ((off % nbytes) != 0) code = 2'd1;
    else code = 2'd0;
    if (code == 2'd0) begin
      for (int b = 0; b < nbytes; b++) be[off + b] = 1'b1;
      case (sz)
        2'd0:    wd = (d & 32'h0000_00FF) * 32'h0101_0101;
        2'd1:    wd = (d & 32'h0000_FFFF) * 32'h0001_0001;
        default: wd = d;
      endcase
    end
  endfunction

  // Entered and left on a negedge; returns at the negedge showing st_done
  task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           input int ack_after, output obs_t o);
    logic got;
    o = '0;
    got = 1'b0;
    check("ready_before_store", {63'b0, st_ready}, 64'd1);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    @(negedge clk);
    st_valid = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      if (st_done) begin
        o.lat         = 8'(c);
        o.err         = st_err;
        o.code        = st_err_code;
        o.be_done     = mem_be;
        o.req_at_done = mem_req;
        got           = 1'b1;
        mem_ack       = 1'b0;
      end else begin
        if (mem_req) begin
          if (o.req_n == 0) begin
            o.addr  = mem_addr;
            o.wdata = mem_wdata;
            o.be    = mem_be;
          end else if (mem_addr !== o.addr || mem_wdata !== o.wdata || mem_be !== o.be) begin
            o.unstable = 1'b1;
          end
          o.req_n = o.req_n + 8'd1;
          mem_ack = (int'(o.req_n) > ack_after);
        end else begin
          mem_ack = 1'b0;
        end
        @(negedge clk);
      end
    end
    o.finished = got;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL store_bound: got no st_done expected st_done within 60 cycles");
    end
  endtask

  task automatic check_obs(input string tag, input obs_t o, input logic [31:0] maddr,
                           input logic [3:0] be, input logic [31:0] wd, input logic err,
                           input logic [1:0] code, input int lat, input int req_n);
    check({tag, "_err"},   {63'b0, o.err}, {63'b0, err});
    check({tag, "_code"},  {62'b0, o.code}, {62'b0, code});
    check({tag, "_lat"},   {56'b0, o.lat}, 64'(lat));
    check({tag, "_reqn"},  {56'b0, o.req_n}, 64'(req_n));
    check({tag, "_bedone"}, {60'b0, o.be_done}, 64'd0);
    check({tag, "_reqdone"}, {63'b0, o.req_at_done}, 64'd0);
    if (req_n > 0) begin
      check({tag, "_addr"},   {32'b0, o.addr}, {32'b0, maddr});
      check({tag, "_be"},     {60'b0, o.be}, {60'b0, be});
      check({tag, "_wdata"},  {32'b0, o.wdata}, {32'b0, wd});
      check({tag, "_stable"}, {63'b0, o.unstable}, 64'd0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    obs_t o;
    logic [3:0]  rbe;
    logic [31:0] rwd;
    logic [1:0]  rcode;
    logic [1:0]  last_code;

    vecs[0] = '{2'd0, 32'h0000_1003, 32'hAABB_CCDD, 0,   32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 1'b0, 2'd0, 2,  1};
    vecs[1] = '{2'd1, 32'h0000_2002, 32'h1234_5678, 3,   32'h0000_2000, 4'b1100, 32'h5678_5678, 1'b0, 2'd0, 5,  4};
    vecs[2] = '{2'd2, 32'h0000_3001, 32'h1111_2222, 0,   32'h0,         4'b0000, 32'h0,         1'b1, 2'd1, 1,  0};
    vecs[3] = '{2'd3, 32'h0000_3001, 32'h1111_2222, 0,   32'h0,         4'b0000, 32'h0,         1'b1, 2'd2, 1,  0};
    vecs[4] = '{2'd2, 32'h0000_4000, 32'h0BAD_F00D, 999, 32'h0000_4000, 4'b1111, 32'h0BAD_F00D, 1'b1, 2'd3, 17, 16};
    vecs[5] = '{2'd2, 32'h0000_4000, 32'h600D_F00D, 15,  32'h0000_4000, 4'b1111, 32'h600D_F00D, 1'b0, 2'd0, 17, 16};
    vecs[6] = '{2'd1, 32'h0000_2001, 32'h1234_5678, 0,   32'h0,         4'b0000, 32'h0,         1'b1, 2'd1, 1,  0};
    vecs[7] = '{2'd0, 32'h0000_0002, 32'h0000_00A5, 1,   32'h0000_0000, 4'b0100, 32'hA5A5_A5A5, 1'b0, 2'd0, 3,  2};
    vecs[8] = '{2'd1, 32'h0000_0000, 32'hFFFF_BEEF, 0,   32'h0000_0000, 4'b0011, 32'hBEEF_BEEF, 1'b0, 2'd0, 2,  1};
    vecs[9] = '{2'd2, 32'h0000_0010, 32'hCAFE_F00D, 0,   32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 1'b0, 2'd0, 2,  1};

    reset    = 1'b1;
    st_valid = 1'b0;
    st_size  = 2'd0;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    mem_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'b0, st_ready}, 64'd1);
    check("rst_req",   {63'b0, mem_req}, 64'd0);
    check("rst_done",  {63'b0, st_done}, 64'd0);
    check("rst_err",   {63'b0, st_err}, 64'd0);
    check("rst_code",  {62'b0, st_err_code}, 64'd0);
    check("rst_addr",  {32'b0, mem_addr}, 64'd0);
    check("rst_wdata", {32'b0, mem_wdata}, 64'd0);
    check("rst_be",    {60'b0, mem_be}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_store(vecs[i].sz, vecs[i].addr, vecs[i].data, vecs[i].ack_after, o);
      check_obs($sformatf("vec%0d", i), o, vecs[i].maddr, vecs[i].be, vecs[i].wdata,
                vecs[i].err, vecs[i].code, vecs[i].lat, vecs[i].req_n);
      last_code = vecs[i].code;
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {63'b0, st_done}, 64'd0);
      check($sformatf("vec%0d_err_pulse", i),  {63'b0, st_err}, 64'd0);
      check($sformatf("vec%0d_code_hold", i),  {62'b0, st_err_code}, {62'b0, last_code});
    end

    // Spurious ack while idle
    mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("spur_req",  {63'b0, mem_req}, 64'd0);
      check("spur_done", {63'b0, st_done}, 64'd0);
    end
    mem_ack = 1'b0;

    // Back-to-back word stores with st_valid held and immediate ack
    begin
      logic [31:0] b2b_addr[4];
      logic [31:0] hs_q[$];
      int idx, n_done, last_acc, cyc;
      logic will_acc;
      b2b_addr = '{32'h0000_5000, 32'h0000_5004, 32'h0000_5008, 32'h0000_500C};
      idx = 0; n_done = 0; last_acc = -1; cyc = 0;
      st_valid = 1'b1; st_size = 2'd2; st_addr = b2b_addr[0]; st_data = 32'h5000;
      while (cyc < 40 && n_done < 4) begin
        if (st_done) n_done++;
        if (mem_req) check("b2b_ready_low", {63'b0, st_ready}, 64'd0);
        if (mem_req) begin
          mem_ack = 1'b1;
          hs_q.push_back(mem_addr);
        end else begin
          mem_ack = 1'b0;
        end
        will_acc = st_valid && st_ready;
        @(negedge clk);
        cyc++;
        if (will_acc) begin
          if (last_acc >= 0) check($sformatf("b2b_gap%0d", idx), 64'(cyc - last_acc), 64'd2);
          last_acc = cyc;
          idx++;
          if (idx < 4) begin
            st_addr = b2b_addr[idx];
            st_data = b2b_addr[idx];
          end else begin
            st_valid = 1'b0;
          end
        end
      end
      mem_ack = 1'b0;
      check("b2b_accepts", 64'(idx), 64'd4);
      check("b2b_dones",   64'(n_done), 64'd4);
      check("b2b_hs_count", 64'(hs_q.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
        if (k < hs_q.size()) check($sformatf("b2b_hs%0d", k), {32'b0, hs_q[k]}, {32'b0, b2b_addr[k]});
      end
      @(negedge clk);
    end

    // Reset in the middle of a pending request
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h0000_6000; st_data = 32'h6;
    @(negedge clk);
    st_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_req_before", {63'b0, mem_req}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_req",   {63'b0, mem_req}, 64'd0);
    check("mid_ready", {63'b0, st_ready}, 64'd1);
    check("mid_done",  {63'b0, st_done}, 64'd0);
    check("mid_be",    {60'b0, mem_be}, 64'd0);
    reset = 1'b0;
    begin
      int spurious_done;
      spurious_done = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (st_done || mem_req) spurious_done++;
      end
      check("mid_no_done", 64'(spurious_done), 64'd0);
    end

    // Random stores against the reference model
    for (int r = 0; r < 150; r++) begin
      logic [1:0]  sz;
      logic [31:0] a, d;
      int ack_after, exp_lat, exp_req;
      logic exp_err;
      logic [1:0] exp_code;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      d  = $urandom;
      ack_after = $urandom_range(0, 20);
      ref_model(sz, a, d, rbe, rwd, rcode);
      if (rcode != 2'd0) begin
        exp_err = 1'b1; exp_code = rcode; exp_lat = 1; exp_req = 0;
      end else if (ack_after < TMO) begin
        exp_err = 1'b0; exp_code = 2'd0; exp_lat = ack_after + 2; exp_req = ack_after + 1;
      end else begin
        exp_err = 1'b1; exp_code = 2'd3; exp_lat = TMO + 1; exp_req = TMO;
      end
      run_store(sz, a, d, ack_after, o);
      check_obs($sformatf("rnd%0d", r), o, {a[31:2], 2'b00}, rbe, rwd, exp_err, exp_code, exp_lat, exp_req);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Write-side counterpart to the immediate/load widening path in the 32-bit MIPS datapath.
- Takes a 32-bit register value from the MEM stage and narrows it to byte (sb), halfword (sh) or word (sw).
- Generates little-endian lane-replicated write data and byte enables.
- Runs a single-outstanding request/acknowledge transaction to data memory, with alignment checking and an acknowledge timeout.

Parameters:
- TIMEOUT, 16, cycles mem_req may wait for mem_ack before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- st_valid  input  1  MEM stage presents a store
- st_ready  output  1  unit can accept a store this cycle
- st_size  input  2  00 byte, 01 halfword, 10 word, 11 invalid
- st_addr  input  32  byte address
- st_data  input  32  register source data (rt)
- st_done  output  1  one-cycle pulse: store finished (success or error)
- st_err  output  1  qualifies st_done: store failed
- st_err_code  output  2  01 misaligned, 10 invalid size, 11 timeout, 00 none; valid with st_done
- mem_req  output  1  write request to data memory
- mem_addr  output  32  word address {st_addr[31:2],2'b00}
- mem_wdata  output  32  lane-placed write data
- mem_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
- mem_ack  input  1  memory accepted the write

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Reset values: state IDLE, st_ready=1, st_done=0, st_err=0, st_err_code=00, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, timeout counter=0.
- FSM states: IDLE, BUSY.
- st_ready = (state==IDLE).
- Accept occurs on st_valid && st_ready; inputs are sampled and registered on that edge.
- Lane rules (little-endian):
  - byte: mem_be = 4'b0001 << st_addr[1:0]; mem_wdata = {4{st_data[7:0]}}.
  - half: mem_be = st_addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{st_data[15:0]}}.
  - word: mem_be = 4'b1111; mem_wdata = st_data.
- Error checks at accept:
  - half with st_addr[0]=1, or word with st_addr[1:0]!=0 -> misaligned (01).
  - st_size=11 -> invalid size (10); invalid size takes priority over misaligned.
- Error path: accept cycle N -> at N+1 st_done=1, st_err=1, code set, state IDLE, mem_req never asserted, mem_be=0.
- Normal path: accept cycle N -> at N+1 state BUSY, mem_req=1, with mem_addr/mem_wdata/mem_be valid. These outputs hold stable while mem_req=1.
- Completion: handshake completes on an edge where mem_req && mem_ack. Next cycle: mem_req=0, mem_be=0, st_done=1, st_err=0, code=00, state IDLE.
- Minimum store latency: accept N, ack at N+1, done at N+2. The next store may be accepted in the same cycle st_done pulses.
- mem_ack while mem_req=0 is ignored.
- st_done and st_err are single-cycle pulses. st_err_code holds its last value until the next st_done.
- Timeout (TIMEOUT>0):
  - Counter clears on entering BUSY and increments each BUSY cycle without ack.
  - If no ack arrives in the cycle where the counter equals TIMEOUT-1: mem_req drops next cycle, st_done=1, st_err=1, code=11, state IDLE.
  - An ack arriving on that same final cycle wins, giving a normal completion.
- st_valid while BUSY: not accepted. The producer holds the store; the unit never drops or duplicates it.
- Reset mid-transaction: the next edge forces the reset values. mem_req drops and no st_done is issued for the aborted store.
- Counter width: $clog2(TIMEOUT+1), minimum 1.

Test Plan:
- sb, addr=0x0000_1003, data=0xAABBCCDD, ack at first req cycle -> mem_addr=0x0000_1000, mem_be=1000, mem_wdata=0xDDDDDDDD, st_done 2 cycles after accept, st_err=0.
- sh addr=0x0000_2002 data=0x1234_5678, ack delayed 3 cycles -> mem_be=1100, mem_wdata=0x56785678, fields stable during all 4 req cycles, single st_done after ack.
- sw addr=0x0000_3001 -> no mem_req, st_done=st_err=1, code=01 next cycle. st_size=11 at addr 0x0000_3001 -> code=10.
- sw addr=0x0000_4000, never ack, TIMEOUT=16 -> mem_req high exactly 16 cycles, then st_done=st_err=1, code=11. Separately, ack on cycle 16 -> normal done, code=00.
- Back-to-back sw stores with st_valid held high and immediate acks -> accepts every 2 cycles, st_ready low while BUSY, exactly one mem handshake per store, no duplicates.
- reset asserted while BUSY with mem_req=1 -> next cycle mem_req=0, st_ready=1, no st_done. Spurious mem_ack while idle -> no effect.
